regfile_rename: RTL and testbench

Parametrised architectural register file with per-register rename tags for the out-of-order core. It sits between the issue stage and the ROB commit path. Dispatched instructions read operand values or producer tags, and rename their destination. Up to NCMT instructions retire per cycle in program order. A flush input drops all speculative renames on mispredict.

---
 rtl/regfile_rename.sv | 127 ++++++++++++
 tb/tb_regfile_rename.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_rename.sv
// Architectural register file with per-register rename tags, commit bypass and flush.
// Reads are combinational (0 cycles); updates land on clk_in; rdy_in low stalls all state.
module regfile_rename #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int TAG_W = 4,
  parameter int NCMT  = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          rdy_in,
  input  logic                          issue_valid,
  input  logic [$clog2(NREG)-1:0]       rs1,
  input  logic [$clog2(NREG)-1:0]       rs2,
  input  logic [$clog2(NREG)-1:0]       rd,
  input  logic [TAG_W-1:0]              rd_tag,
  input  logic [NCMT-1:0]               cmt_valid,
  input  logic [NCMT*$clog2(NREG)-1:0]  cmt_rd,
  input  logic [NCMT*TAG_W-1:0]         cmt_tag,
  input  logic [NCMT*XLEN-1:0]          cmt_val,
  input  logic                          flush,
  output logic [XLEN-1:0]               vj,
  output logic [XLEN-1:0]               vk,
  output logic [TAG_W-1:0]              qj,
  output logic [TAG_W-1:0]              qk,
  output logic [$clog2(NREG):0]         busy_cnt
);
  localparam int AW = $clog2(NREG);

  logic [XLEN-1:0]  val_q [NREG];
  logic [TAG_W-1:0] tag_q [NREG];
  logic [XLEN-1:0]  val_d [NREG];
  logic [TAG_W-1:0] tag_d [NREG];
  logic             cmt_clr;

  // Two identical read ports; the highest matching commit channel forwards its value.
  for (genvar s = 0; s < 2; s++) begin : g_rd
    logic [AW-1:0]    idx;
    logic [TAG_W-1:0] cur_tag;
    logic             byp_hit;
    logic [XLEN-1:0]  byp_val;
    logic [XLEN-1:0]  v;
    logic [TAG_W-1:0] q;

    assign idx     = (s == 0) ? rs1 : rs2;
    assign cur_tag = tag_q[idx];

    always_comb begin
      byp_hit = 1'b0;
      byp_val = '0;
      for (int k = 0; k < NCMT; k++) begin
        if (rdy_in && cmt_valid[k] && (cur_tag != '0) &&
            (cmt_tag[k*TAG_W +: TAG_W] == cur_tag)) begin
          byp_hit = 1'b1;
          byp_val = cmt_val[k*XLEN +: XLEN];
        end
      end
    end

    always_comb begin
      v = '0;
      q = '0;
      if (issue_valid && (idx != '0)) begin
        if (flush) begin
          v = byp_hit ? byp_val : val_q[idx];
        end else if (byp_hit) begin
          v = byp_val;
        end else if (cur_tag == '0) begin
          v = val_q[idx];
        end else begin
          q = cur_tag;
        end
      end
    end
  end

  assign vj = g_rd[0].v;
  assign qj = g_rd[0].q;
  assign vk = g_rd[1].v;
  assign qk = g_rd[1].q;

  // Per entry: last commit channel targeting it decides both value and tag clear.
  always_comb begin
    val_d   = val_q;
    tag_d   = tag_q;
    cmt_clr = 1'b0;
    if (rdy_in) begin
      for (int i = 1; i < NREG; i++) begin
        cmt_clr = 1'b0;
        for (int k = 0; k < NCMT; k++) begin
          if (cmt_valid[k] && (cmt_rd[k*AW +: AW] == AW'(i))) begin
            val_d[i] = cmt_val[k*XLEN +: XLEN];
            cmt_clr  = (cmt_tag[k*TAG_W +: TAG_W] != '0) &&
                       (cmt_tag[k*TAG_W +: TAG_W] == tag_q[i]);
          end
        end
        if (flush) begin
          tag_d[i] = '0;
        end else if (issue_valid && (rd == AW'(i))) begin
          tag_d[i] = rd_tag;
        end else if (cmt_clr) begin
          tag_d[i] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int i = 0; i < NREG; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
    end else begin
      val_q <= val_d;
      tag_q <= tag_d;
    end
  end

  always_comb begin
    busy_cnt = '0;
    for (int i = 1; i < NREG; i++) begin
      if (tag_q[i] != '0) busy_cnt = busy_cnt + (AW+1)'(1);
    end
  end

endmodule

// File: tb/tb_regfile_rename.sv
// Table-driven directed vectors, hand sequences and a randomized reference-model run for regfile_rename.
module tb_regfile_rename;
  localparam int XLEN = 32, NREG = 32, TAG_W = 4, NCMT = 2, AW = 5;

  logic              clk_in = 1'b0;
  logic              rst_in, rdy_in, issue_valid, flush;
  logic [AW-1:0]     rs1, rs2, rd;
  logic [TAG_W-1:0]  rd_tag;
  logic [NCMT-1:0]   cmt_valid;
  logic [NCMT*AW-1:0]    cmt_rd;
  logic [NCMT*TAG_W-1:0] cmt_tag;
  logic [NCMT*XLEN-1:0]  cmt_val;
  logic [XLEN-1:0]   vj, vk;
  logic [TAG_W-1:0]  qj, qk;
  logic [AW:0]       busy_cnt;

  regfile_rename #(.XLEN(XLEN), .NREG(NREG), .TAG_W(TAG_W), .NCMT(NCMT)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .issue_valid(issue_valid),
    .rs1(rs1), .rs2(rs2), .rd(rd), .rd_tag(rd_tag),
    .cmt_valid(cmt_valid), .cmt_rd(cmt_rd), .cmt_tag(cmt_tag), .cmt_val(cmt_val),
    .flush(flush), .vj(vj), .vk(vk), .qj(qj), .qk(qk), .busy_cnt(busy_cnt)
  );

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    bit iv; bit [AW-1:0] rs1, rs2, rd; bit [TAG_W-1:0] rdt;
    bit [1:0] cv; bit [AW-1:0] cr0, cr1; bit [TAG_W-1:0] ct0, ct1; bit [31:0] cv0, cv1;
    bit fl, rdy;
    bit [31:0] evj, evk; bit [TAG_W-1:0] eqj, eqk; bit [5:0] eb;
  } vec_t;

  function automatic vec_t mk(input bit iv, input int r1, input int r2, input int d, input int dt,
                              input bit [1:0] cv, input int c0, input int t0, input bit [31:0] x0,
                              input int c1, input int t1, input bit [31:0] x1,
                              input bit fl, input bit rdy,
                              input bit [31:0] evj, input int eqj,
                              input bit [31:0] evk, input int eqk, input int eb);
    vec_t t;
    t.iv = iv; t.rs1 = AW'(r1); t.rs2 = AW'(r2); t.rd = AW'(d); t.rdt = TAG_W'(dt);
    t.cv = cv; t.cr0 = AW'(c0); t.ct0 = TAG_W'(t0); t.cv0 = x0;
    t.cr1 = AW'(c1); t.ct1 = TAG_W'(t1); t.cv1 = x1;
    t.fl = fl; t.rdy = rdy;
    t.evj = evj; t.eqj = TAG_W'(eqj); t.evk = evk; t.eqk = TAG_W'(eqk); t.eb = 6'(eb);
    return t;
  endfunction

  task automatic drive(input bit iv, input int r1, input int r2, input int d, input int dt,
                       input bit [1:0] cv, input int c0, input int t0, input bit [31:0] x0,
                       input int c1, input int t1, input bit [31:0] x1,
                       input bit fl, input bit rdy);
    issue_valid = iv; rs1 = AW'(r1); rs2 = AW'(r2); rd = AW'(d); rd_tag = TAG_W'(dt);
    cmt_valid = cv;
    cmt_rd  = {AW'(c1), AW'(c0)};
    cmt_tag = {TAG_W'(t1), TAG_W'(t0)};
    cmt_val = {x1, x0};
    flush = fl; rdy_in = rdy;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Reference model: plain arrays updated from the behavioural rules.
  logic [XLEN-1:0]  m_val [NREG];
  logic [TAG_W-1:0] m_tag [NREG];

  task automatic m_reset();
    for (int i = 0; i < NREG; i++) begin m_val[i] = '0; m_tag[i] = '0; end
  endtask

  task automatic m_read(input int a, output logic [XLEN-1:0] v, output logic [TAG_W-1:0] q);
    logic hit;
    logic [XLEN-1:0] hv;
    v = '0; q = '0; hit = 0; hv = '0;
    if (!issue_valid || a == 0) return;
    for (int k = 0; k < NCMT; k++)
      if (rdy_in && cmt_valid[k] && m_tag[a] != 0 && cmt_tag[k*TAG_W +: TAG_W] == m_tag[a]) begin
        hit = 1; hv = cmt_val[k*XLEN +: XLEN];
      end
    if (flush) v = hit ? hv : m_val[a];
    else if (hit) v = hv;
    else if (m_tag[a] == 0) v = m_val[a];
    else q = m_tag[a];
  endtask

  function automatic int m_busy();
    int n = 0;
    for (int i = 1; i < NREG; i++) if (m_tag[i] != 0) n++;
    return n;
  endfunction

  task automatic m_update();
    logic [TAG_W-1:0] old [NREG];
    bit clr [NREG];
    int r;
    if (!rdy_in) return;
    for (int i = 0; i < NREG; i++) begin old[i] = m_tag[i]; clr[i] = 0; end
    for (int k = 0; k < NCMT; k++) begin
      r = int'(cmt_rd[k*AW +: AW]);
      if (cmt_valid[k] && r != 0) begin
        m_val[r] = cmt_val[k*XLEN +: XLEN];
        clr[r] = (cmt_tag[k*TAG_W +: TAG_W] != 0) && (cmt_tag[k*TAG_W +: TAG_W] == old[r]);
      end
    end
    for (int i = 1; i < NREG; i++) if (clr[i]) m_tag[i] = '0;
    if (flush) begin
      for (int i = 1; i < NREG; i++) m_tag[i] = '0;
    end else if (issue_valid && rd != 0) begin
      m_tag[rd] = rd_tag;
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [XLEN-1:0] ev;
    logic [TAG_W-1:0] eq;
    int c0, c1;

    // iv rs1 rs2 rd rdt | cv cr0 ct0 cval0 cr1 ct1 cval1 | fl rdy || vj qj vk qk busy
    vecs.push_back(mk(1, 5, 0, 0, 0,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 3, 7,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 3, 3, 0, 0,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  0, 7, 0, 7, 1));
    vecs.push_back(mk(0, 3, 3, 0, 0,  2'b01, 3, 7, 32'hDEADBEEF, 0, 0, 0, 0, 1,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 3, 5, 0, 0,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  32'hDEADBEEF, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 4, 2,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 4, 0, 4, 5,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  0, 2, 0, 0, 1));
    vecs.push_back(mk(1, 4, 0, 0, 0,  2'b01, 4, 2, 32'h11,  0, 0, 0,      0, 1,  0, 5, 0, 0, 1));
    vecs.push_back(mk(1, 4, 4, 0, 0,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  0, 5, 0, 5, 1));
    vecs.push_back(mk(1, 0, 0, 6, 9,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 6, 4, 6, 10, 2'b01, 6, 9, 32'h1234, 0, 0, 0,     0, 1,  32'h1234, 0, 0, 5, 2));
    vecs.push_back(mk(1, 6, 0, 0, 0,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  0, 10, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0, 8, 3,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  0, 0, 0, 0, 2));
    vecs.push_back(mk(1, 8, 0, 0, 0,  2'b11, 8, 3, 32'hA,   8, 4, 32'hB,  0, 1,  32'hA, 0, 0, 0, 3));
    vecs.push_back(mk(1, 8, 6, 0, 0,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  0, 3, 0, 10, 3));
    vecs.push_back(mk(1, 8, 0, 0, 0,  2'b10, 8, 3, 32'hF,   8, 3, 32'hC,  0, 1,  32'hC, 0, 0, 0, 3));
    vecs.push_back(mk(1, 8, 0, 0, 0,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  32'hC, 0, 0, 0, 2));
    vecs.push_back(mk(1, 6, 7, 0, 0,  2'b11, 6, 10, 32'h100, 7, 10, 32'h200, 0, 1, 32'h200, 0, 0, 0, 2));
    vecs.push_back(mk(1, 6, 7, 0, 0,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  32'h100, 0, 32'h200, 0, 1));
    vecs.push_back(mk(1, 9, 0, 0, 0,  2'b01, 9, 0, 32'h55,  0, 0, 0,      0, 1,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 9, 0, 0, 0,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  32'h55, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 3,  2'b01, 0, 0, 32'h77,  0, 0, 0,      0, 1,  0, 0, 0, 0, 1));
    vecs.push_back(mk(1, 0, 9, 0, 0,  2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  0, 0, 32'h55, 0, 1));
    vecs.push_back(mk(1, 4, 9, 10, 6, 2'b01, 4, 5, 32'h99,  0, 0, 0,      0, 0,  0, 5, 32'h55, 0, 1));
    vecs.push_back(mk(1, 4, 10, 0, 0, 2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  0, 5, 0, 0, 1));
    vecs.push_back(mk(1, 4, 9, 11, 2, 2'b00, 0, 0, 0,       0, 0, 0,      1, 1,  32'h11, 0, 32'h55, 0, 1));
    vecs.push_back(mk(1, 4, 11, 0, 0, 2'b00, 0, 0, 0,       0, 0, 0,      0, 1,  32'h11, 0, 0, 0, 0));

    idle();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].iv, int'(vecs[i].rs1), int'(vecs[i].rs2), int'(vecs[i].rd), int'(vecs[i].rdt),
            vecs[i].cv, int'(vecs[i].cr0), int'(vecs[i].ct0), vecs[i].cv0,
            int'(vecs[i].cr1), int'(vecs[i].ct1), vecs[i].cv1, vecs[i].fl, vecs[i].rdy);
      #2;
      chk($sformatf("vec%0d vj", i), vj, vecs[i].evj);
      chk($sformatf("vec%0d qj", i), 32'(qj), 32'(vecs[i].eqj));
      chk($sformatf("vec%0d vk", i), vk, vecs[i].evk);
      chk($sformatf("vec%0d qk", i), 32'(qk), 32'(vecs[i].eqk));
      chk($sformatf("vec%0d busy", i), 32'(busy_cnt), 32'(vecs[i].eb));
      tick();
    end

    // Asynchronous reset asserted mid-cycle clears state immediately.
    drive(1, 0, 0, 2, 1, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    tick();
    drive(1, 3, 2, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("pre_rst vj", vj, 32'hDEADBEEF);
    chk("pre_rst qk", 32'(qk), 32'd1);
    rst_in = 1'b1;
    #1;
    chk("in_rst vj", vj, 32'd0);
    chk("in_rst qk", 32'(qk), 32'd0);
    chk("in_rst busy", 32'(busy_cnt), 32'd0);
    rst_in = 1'b0;
    drive(1, 5, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("post_rst vj", vj, 32'd0);
    chk("post_rst qj", 32'(qj), 32'd0);
    chk("post_rst vk", vk, 32'd0);
    tick();

    // Rename x1..x10, stall with flush pending, then release.
    for (int i = 1; i <= 10; i++) begin
      drive(1, 0, 0, i, i, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    drive(1, 5, 10, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("ren10 busy", 32'(busy_cnt), 32'd10);
    chk("ren10 qj", 32'(qj), 32'd5);
    chk("ren10 qk", 32'(qk), 32'd10);
    tick();
    for (int c = 0; c < 3; c++) begin
      drive(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 0);
      #1;
      chk($sformatf("stall%0d busy", c), 32'(busy_cnt), 32'd10);
      tick();
    end
    drive(1, 0, 0, 12, 3, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1);
    tick();
    drive(1, 12, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
    #1;
    chk("flush busy", 32'(busy_cnt), 32'd0);
    chk("flush x12 qj", 32'(qj), 32'd0);
    chk("flush x1 qk", 32'(qk), 32'd0);
    tick();

    // Randomized run against the reference model.
    idle();
    rst_in = 1'b1;
    #1;
    rst_in = 1'b0;
    m_reset();
    tick();
    for (int n = 0; n < 1500; n++) begin
      c0 = $urandom_range(0, 7);
      c1 = ($urandom_range(0, 3) == 0) ? c0 : $urandom_range(0, 7);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 15),
            2'($urandom_range(0, 3)),
            c0, ($urandom_range(0, 9) < 6) ? int'(m_tag[c0]) : $urandom_range(0, 15), $urandom,
            c1, ($urandom_range(0, 9) < 6) ? int'(m_tag[c1]) : $urandom_range(0, 15), $urandom,
            0, $urandom_range(0, 9) != 0);
      if (rdy_in && $urandom_range(0, 19) == 0) flush = 1'b1;
      #2;
      m_read(int'(rs1), ev, eq);
      chk($sformatf("rnd%0d vj", n), vj, ev);
      chk($sformatf("rnd%0d qj", n), 32'(qj), 32'(eq));
      m_read(int'(rs2), ev, eq);
      chk($sformatf("rnd%0d vk", n), vk, ev);
      chk($sformatf("rnd%0d qk", n), 32'(qk), 32'(eq));
      chk($sformatf("rnd%0d busy", n), 32'(busy_cnt), 32'(m_busy()));
      m_update();
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
